// File: rtl/ram_loader_arbiter.sv
// Arbitrates the CPU RAM port between the microcoded CPU and an external loader.
// The loader is granted only at instruction boundaries and runs timed single-word accesses.
module ram_loader_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_BURST     = 16
) (
  input  logic              i_nclk,
  input  logic              i_reset,
  input  logic              i_instrFinishedN,
  output logic              o_cpuHalt,
  output logic              o_busSel,
  input  logic              i_ldrReq,
  output logic              o_ldrGrant,
  input  logic              i_ldrStb,
  input  logic              i_ldrWrite,
  input  logic [ADDR_W-1:0] i_ldrAddr,
  input  logic [DATA_W-1:0] i_ldrData,
  output logic              o_ldrAck,
  output logic [DATA_W-1:0] o_ldrData,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic [DATA_W-1:0] o_ramData,
  output logic              o_ramNWE,
  output logic              o_ramNOE,
  input  logic [DATA_W-1:0] i_ramData
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [SW-1:0] STB_LAST  = SW'(STROBE_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_GRANT, S_SETUP, S_STROBE, S_HOLD, S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [SW-1:0]     stb_cnt_q, stb_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              write_q, write_d;

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // logic lives in the always_comb below so this block stays a plain register bank.
  always_ff @(posedge i_nclk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      burst_q   <= '0;
      stb_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      stb_cnt_q <= stb_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    stb_cnt_d  = stb_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    o_cpuHalt  = 1'b0;
    o_busSel   = 1'b0;
    o_ldrGrant = 1'b0;
    o_ldrAck   = 1'b0;
    o_ramNWE   = 1'b1;
    o_ramNOE   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_ldrReq) begin
          state_d = S_DRAIN;
          burst_d = '0;
        end
      end
      S_DRAIN: begin
        o_cpuHalt = 1'b1;
        if (!i_instrFinishedN) state_d = S_GRANT;
        else if (!i_ldrReq)    state_d = S_IDLE;
      end
      S_GRANT: begin
        o_cpuHalt  = 1'b1;
        o_busSel   = 1'b1;
        o_ldrGrant = 1'b1;
        // A strobe in the same cycle as a request drop still starts the access.
        if (i_ldrStb) begin
          state_d = S_SETUP;
          addr_d  = i_ldrAddr;
          wdata_d = i_ldrData;
          write_d = i_ldrWrite;
        end else if (!i_ldrReq) begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        o_cpuHalt  = 1'b1;
        o_busSel   = 1'b1;
        o_ldrGrant = 1'b1;
        stb_cnt_d  = '0;
        state_d    = S_STROBE;
      end
      S_STROBE: begin
        o_cpuHalt  = 1'b1;
        o_busSel   = 1'b1;
        o_ldrGrant = 1'b1;
        o_ramNWE   = !write_q;
        o_ramNOE   = write_q;
        if (stb_cnt_q == STB_LAST) begin
          if (!write_q) rdata_d = i_ramData;
          state_d = S_HOLD;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        o_cpuHalt  = 1'b1;
        o_busSel   = 1'b1;
        o_ldrGrant = 1'b1;
        o_ldrAck   = 1'b1;
        burst_d    = burst_q + 1'b1;
        if (burst_d == BURST_MAX) state_d = S_RELEASE;
        else if (!i_ldrReq)       state_d = S_IDLE;
        else                      state_d = S_GRANT;
      end
      S_RELEASE: begin
        // CPU runs freely here until it completes at least one instruction.
        if (!i_instrFinishedN) begin
          burst_d = '0;
          state_d = i_ldrReq ? S_DRAIN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ramAddr = addr_q;
  assign o_ramData = wdata_q;
  assign o_ldrData = rdata_q;

endmodule
